hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Consumer end of the per-instruction A/Tuse/Tnew hazard descriptors emitted by the D-stage decoder.
//  Tracks each in-flight destination register and its remaining Tnew through E/M/W.
//  Compares them against the D-stage source Tuse values.
//  Drives the D-stage stall and all forwarding-mux selects for the 5-stage MIPS pipeline.
//  Also owns the MDU busy counter that stalls HI/LO-class instructions.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles after a mult/multu leaves E
//  DIV_CYCLES   10  busy cycles after a div/divu leaves E
// PORTS
//  clk          in   1  rising-edge clock
//  reset_n      in   1  asynchronous, active-low reset
//  A1_D         in   5  rs-side source register of D-stage instr (0 = none)
//  Tuse1_D      in   2  cycles until A1 value is consumed
//  A2_D         in   5  rt-side source register
//  Tuse2_D      in   2  cycles until A2 value is consumed
//  A3_D         in   5  destination register (0 = none)
//  Tnew_D       in   2  cycles, counted from D, until result exists
//  MDUreq_D     in   1  D instr uses the MDU (mult/div/mfhi/mflo/mthi/mtlo)
//  mdu_start_E  in   1  mult/div class instr is in E this cycle
//  mdu_div_E    in   1  that instr is div/divu (selects DIV_CYCLES)
//  flush        in   1  exception/eret: squash every tracked instr
//  stall_D      out  1  hold PC/IF-ID regs, insert bubble into E
//  mdu_busy     out  1  MDU counter non-zero
//  fwd_rs_D     out  2  D-stage rs compare-operand select
//  fwd_rt_D     out  2  D-stage rt compare-operand select
//  fwd_rs_E     out  2  E-stage ALU operand A select
//  fwd_rt_E     out  2  E-stage ALU operand B select
//  fwd_rt_M     out  2  M-stage store-data select
// BEHAVIOUR
//  Fwd encoding: 0 = RF/pipeline reg, 1 = from W, 2 = from M, 3 = from E.
//  - fwd_rt_M is only ever 0 or 1.
//  - fwd_*_E are only ever 0, 1 or 2.
//  Tracking regs per stage:
//  - E: A1_E, A2_E, A3_E, Tnew_E.
//  - M: A2_M, A3_M, Tnew_M.
//  - W: A3_W.
//  Tnew of W is implicitly 0.
//  Each edge, normal advance:
//  - E <= D with Tnew_E = sat0(Tnew_D-1).
//  - M <= E with Tnew_M = sat0(Tnew_E-1).
//  - W <= M.
//  If stall_D=1, E loads a bubble: all A=0, Tnew=0. M and W still advance (E/M/W never stall).
//  flush=1: E, M and W regs all load bubble; flush wins over stall. The MDU counter is unaffected.
//  Stall condition, combinational, for i in {1,2} with Ai_D != 0:
//  - (Ai_D==A3_E && Tnew_E > Tusei_D), or
//  - (Ai_D==A3_M && Tnew_M > Tusei_D).
//  - OR additionally MDUreq_D && (mdu_start_E || mdu_busy).
//  Forward match requires a nonzero register, equal numbers, and producer Tnew==0.
//  The youngest producer has priority: E > M > W.
//  - D selects may be 3/2/1.
//  - E selects (A1_E/A2_E) may be 2/1.
//  - fwd_rt_M (A2_M vs A3_W) may be 1.
//  Stall and forward selects are combinational from tracking regs plus D inputs, with no added latency.
//  MDU counter (4 bits minimum, sized to max(MULT_CYCLES, DIV_CYCLES)):
//  - If mdu_start_E, load DIV_CYCLES when mdu_div_E=1, else MULT_CYCLES.
//  - Else decrement while non-zero.
//  - mdu_busy = (cnt != 0).
//  Reset, async, when reset_n=0:
//  - All tracking regs and the counter go to 0.
//  - Hence stall_D=0, mdu_busy=0, all fwd=0.
//  - Reset mid-operation abandons the MDU count immediately.
//  Register $0 never causes a stall or a forward, even when A3_x==0 matches.
// STRUCTURE
//  Shared define header holds:
//  - FWD_RF/FWD_W/FWD_M/FWD_E encodings.
//  - Tuse/Tnew width (2).
//  - MULT_CYCLES/DIV_CYCLES defaults.
//  Sub-module hazard_fwd_sel: inputs A, (A3,Tnew) x3 -> 2-bit select.
//  - Instantiated five times.
//  - Unused stage inputs are tied to A3=0.
//  The top module holds the stage regs, the stall logic and the MDU counter.
// TESTING
//  - lw $t0 (Tnew 3) then addu using $t0 (Tuse 1):
//    - stall_D=1 for exactly 1 cycle.
//    - Next cycle, fwd_rs_E=1 (from W).
//  - addu $t1 (Tnew 2) then beq $t1 (Tuse 0):
//    - stall_D=1 for 1 cycle.
//    - Then fwd_rs_D=2 (from M).
//  - jal (A3=31, Tnew 1) then jr $ra (Tuse 0):
//    - No stall.
//    - fwd_rs_D=3 (from E).
//  - Producer writes $0 with Tnew 3, consumer reads $0: stall_D=0, all fwd=0.
//  - div enters E (mdu_start_E=1, mdu_div_E=1), then mflo held in D with MDUreq_D=1:
//    - stall_D=1 for 11 cycles (start cycle + 10 busy).
//    - mdu_busy falls after 10.
//  - While lw is in E, a mid-stall event occurs:
//    - flush=1 together with stall: next cycle all tracking regs are 0 and stall_D=0.
//    - Separately, reset_n pulse: all outputs are 0 asynchronously.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths, forwarding-select encodings and MDU latency defaults.
package hazard_ctrl_pkg;
  localparam int RW = 5;
  localparam int TW = 2;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_W  = 2'd1,
    FWD_M  = 2'd2,
    FWD_E  = 2'd3
  } fwd_e;
  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction
endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// hazard_fwd_sel: picks the youngest ready producer (E > M > W) of a nonzero source register.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [RW-1:0] a_i,
  input  logic [RW-1:0] a3_e_i,
  input  logic [TW-1:0] tnew_e_i,
  input  logic [RW-1:0] a3_m_i,
  input  logic [TW-1:0] tnew_m_i,
  input  logic [RW-1:0] a3_w_i,
  input  logic [TW-1:0] tnew_w_i,
  output logic [1:0]    sel_o
);
  logic hit_e, hit_m, hit_w;
  assign hit_e = (a_i != '0) && (a_i == a3_e_i) && (tnew_e_i == '0);
  assign hit_m = (a_i != '0) && (a_i == a3_m_i) && (tnew_m_i == '0);
  assign hit_w = (a_i != '0) && (a_i == a3_w_i) && (tnew_w_i == '0);
  assign sel_o = hit_e ? FWD_E : hit_m ? FWD_M : hit_w ? FWD_W : FWD_RF;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks in-flight destinations through E/M/W, drives D-stage stall,
// all forwarding selects and the MDU busy counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [RW-1:0] A1_D,
  input  logic [TW-1:0] Tuse1_D,
  input  logic [RW-1:0] A2_D,
  input  logic [TW-1:0] Tuse2_D,
  input  logic [RW-1:0] A3_D,
  input  logic [TW-1:0] Tnew_D,
  input  logic          MDUreq_D,
  input  logic          mdu_start_E,
  input  logic          mdu_div_E,
  input  logic          flush,
  output logic          stall_D,
  output logic          mdu_busy,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic [1:0]    fwd_rs_E,
  output logic [1:0]    fwd_rt_E,
  output logic [1:0]    fwd_rt_M
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);
  logic [RW-1:0] a1_e_q, a2_e_q, a3_e_q, a2_m_q, a3_m_q, a3_w_q;
  logic [RW-1:0] a1_e_d, a2_e_d, a3_e_d, a2_m_d, a3_m_d, a3_w_d;
  logic [TW-1:0] tnew_e_q, tnew_m_q, tnew_e_d, tnew_m_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          haz1, haz2, bub_e;
  assign haz1 = (A1_D != '0) && ((A1_D == a3_e_q && tnew_e_q > Tuse1_D) ||
                                 (A1_D == a3_m_q && tnew_m_q > Tuse1_D));
  assign haz2 = (A2_D != '0) && ((A2_D == a3_e_q && tnew_e_q > Tuse2_D) ||
                                 (A2_D == a3_m_q && tnew_m_q > Tuse2_D));
  assign mdu_busy = (cnt_q != '0);
  assign stall_D  = haz1 || haz2 || (MDUreq_D && (mdu_start_E || mdu_busy));
  assign bub_e    = flush || stall_D;
  always_comb begin
    a1_e_d   = bub_e ? '0 : A1_D;
    a2_e_d   = bub_e ? '0 : A2_D;
    a3_e_d   = bub_e ? '0 : A3_D;
    tnew_e_d = bub_e ? '0 : sat_dec(Tnew_D);
    a2_m_d   = flush ? '0 : a2_e_q;
    a3_m_d   = flush ? '0 : a3_e_q;
    tnew_m_d = flush ? '0 : sat_dec(tnew_e_q);
    a3_w_d   = flush ? '0 : a3_m_q;
    cnt_d    = mdu_start_E ? (mdu_div_E ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) :
               (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a1_e_q   <= '0;
      a2_e_q   <= '0;
      a3_e_q   <= '0;
      tnew_e_q <= '0;
      a2_m_q   <= '0;
      a3_m_q   <= '0;
      tnew_m_q <= '0;
      a3_w_q   <= '0;
      cnt_q    <= '0;
    end else begin
      a1_e_q   <= a1_e_d;
      a2_e_q   <= a2_e_d;
      a3_e_q   <= a3_e_d;
      tnew_e_q <= tnew_e_d;
      a2_m_q   <= a2_m_d;
      a3_m_q   <= a3_m_d;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_w_d;
      cnt_q    <= cnt_d;
    end
  end
  // W results are always ready; stages a select cannot source from are tied to $0.
  hazard_fwd_sel u_rs_d (
    .a_i(A1_D), .a3_e_i(a3_e_q), .tnew_e_i(tnew_e_q), .a3_m_i(a3_m_q), .tnew_m_i(tnew_m_q),
    .a3_w_i(a3_w_q), .tnew_w_i('0), .sel_o(fwd_rs_D)
  );
  hazard_fwd_sel u_rt_d (
    .a_i(A2_D), .a3_e_i(a3_e_q), .tnew_e_i(tnew_e_q), .a3_m_i(a3_m_q), .tnew_m_i(tnew_m_q),
    .a3_w_i(a3_w_q), .tnew_w_i('0), .sel_o(fwd_rt_D)
  );
  hazard_fwd_sel u_rs_e (
    .a_i(a1_e_q), .a3_e_i('0), .tnew_e_i('0), .a3_m_i(a3_m_q), .tnew_m_i(tnew_m_q),
    .a3_w_i(a3_w_q), .tnew_w_i('0), .sel_o(fwd_rs_E)
  );
  hazard_fwd_sel u_rt_e (
    .a_i(a2_e_q), .a3_e_i('0), .tnew_e_i('0), .a3_m_i(a3_m_q), .tnew_m_i(tnew_m_q),
    .a3_w_i(a3_w_q), .tnew_w_i('0), .sel_o(fwd_rt_E)
  );
  hazard_fwd_sel u_rt_m (
    .a_i(a2_m_q), .a3_e_i('0), .tnew_e_i('0), .a3_m_i('0), .tnew_m_i('0),
    .a3_w_i(a3_w_q), .tnew_w_i('0), .sel_o(fwd_rt_M)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed pipeline scenarios plus random traffic, checked against
// an instruction-level model (each slot keeps the whole instruction and its age).
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] A1_D, A2_D, A3_D;
  logic [1:0] Tuse1_D, Tuse2_D, Tnew_D;
  logic       MDUreq_D, mdu_start_E, mdu_div_E, flush;
  logic       stall_D, mdu_busy;
  logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;

  hazard_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .A1_D(A1_D), .Tuse1_D(Tuse1_D), .A2_D(A2_D), .Tuse2_D(Tuse2_D),
    .A3_D(A3_D), .Tnew_D(Tnew_D), .MDUreq_D(MDUreq_D),
    .mdu_start_E(mdu_start_E), .mdu_div_E(mdu_div_E), .flush(flush),
    .stall_D(stall_D), .mdu_busy(mdu_busy),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D), .fwd_rs_E(fwd_rs_E),
    .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M)
  );

  always #5 clk = ~clk;

  typedef struct {
    int a1;
    int a2;
    int a3;
    int tnew;
  } ins_t;

  ins_t pipe[1:3];
  ins_t din;
  int   tu1, tu2, m_mr, m_ms, m_md, m_fl;
  int   cyc = 0;
  int   busy_until = 0;
  int   checks = 0;
  int   errors = 0;

  // Cycles a slot's result still needs: Tnew counted from D minus stages travelled.
  function automatic int rem(int k);
    return (pipe[k].tnew > k) ? pipe[k].tnew - k : 0;
  endfunction

  function automatic int exp_busy();
    return (cyc < busy_until) ? 1 : 0;
  endfunction

  function automatic int hz(int a, int tu);
    if (a == 0) return 0;
    for (int k = 1; k <= 2; k++)
      if (pipe[k].a3 == a && rem(k) > tu) return 1;
    return 0;
  endfunction

  function automatic int exp_stall();
    return (hz(din.a1, tu1) || hz(din.a2, tu2) ||
            (m_mr != 0 && (m_ms != 0 || exp_busy() != 0))) ? 1 : 0;
  endfunction

  // Youngest ready producer among slots first..3; slot k encodes as 4-k (E=3, M=2, W=1).
  function automatic int fsel(int a, int first);
    if (a == 0) return 0;
    for (int k = first; k <= 3; k++)
      if (pipe[k].a3 == a && rem(k) == 0) return 4 - k;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("stall_D", {7'd0, stall_D}, exp_stall());
    chk("mdu_busy", {7'd0, mdu_busy}, exp_busy());
    chk("fwd_rs_D", {6'd0, fwd_rs_D}, fsel(din.a1, 1));
    chk("fwd_rt_D", {6'd0, fwd_rt_D}, fsel(din.a2, 1));
    chk("fwd_rs_E", {6'd0, fwd_rs_E}, fsel(pipe[1].a1, 2));
    chk("fwd_rt_E", {6'd0, fwd_rt_E}, fsel(pipe[1].a2, 2));
    chk("fwd_rt_M", {6'd0, fwd_rt_M}, fsel(pipe[2].a2, 3));
  endtask

  task automatic drive(input int a1, t1, a2, t2, a3, tn,
                       input int mr = 0, ms = 0, md = 0, fl = 0);
    A1_D = 5'(a1); Tuse1_D = 2'(t1); A2_D = 5'(a2); Tuse2_D = 2'(t2);
    A3_D = 5'(a3); Tnew_D = 2'(tn);
    MDUreq_D = mr[0]; mdu_start_E = ms[0]; mdu_div_E = md[0]; flush = fl[0];
    din = '{a1, a2, a3, tn};
    tu1 = t1; tu2 = t2; m_mr = mr; m_ms = ms; m_md = md; m_fl = fl;
    #1;
    check_model();
  endtask

  task automatic tick();
    int st;
    st = exp_stall();
    @(posedge clk);
    cyc++;
    if (m_ms != 0) busy_until = cyc + ((m_md != 0) ? 10 : 5);
    if (m_fl != 0) begin
      for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};
    end else begin
      pipe[3] = pipe[2];
      pipe[2] = pipe[1];
      pipe[1] = (st != 0) ? '{0, 0, 0, 0} : din;
    end
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, {7'd0, stall_D}, 0);
    chk({tag, "_busy"}, {7'd0, mdu_busy}, 0);
    chk({tag, "_fwd"}, {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}, 0);
    chk({tag, "_fwdM"}, {6'd0, fwd_rt_M}, 0);
  endtask

  initial begin
    int nst, nb;
    for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};
    reset_n = 1'b0;
    A1_D = '0; A2_D = '0; A3_D = '0; Tuse1_D = '0; Tuse2_D = '0; Tnew_D = '0;
    MDUreq_D = 0; mdu_start_E = 0; mdu_div_E = 0; flush = 0;
    din = '{0, 0, 0, 0};
    tu1 = 0; tu2 = 0; m_mr = 0; m_ms = 0; m_md = 0; m_fl = 0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;
    nops(3);

    // lw $t0 (Tnew 3) then addu reading $t0 at Tuse 1
    drive(29, 1, 0, 3, 8, 3);
    tick();
    drive(8, 1, 9, 1, 10, 2);
    chk("lw_use_stall", {7'd0, stall_D}, 1);
    tick();
    drive(8, 1, 9, 1, 10, 2);
    chk("lw_use_release", {7'd0, stall_D}, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("lw_use_fwd_rs_E", {6'd0, fwd_rs_E}, 1);
    tick();
    nops(3);

    // addu $t1 (Tnew 2) then beq on $t1 (Tuse 0)
    drive(0, 3, 0, 3, 9, 2);
    tick();
    drive(9, 0, 0, 0, 0, 0);
    chk("beq_stall", {7'd0, stall_D}, 1);
    tick();
    drive(9, 0, 0, 0, 0, 0);
    chk("beq_release", {7'd0, stall_D}, 0);
    chk("beq_fwd_rs_D", {6'd0, fwd_rs_D}, 2);
    tick();
    nops(3);

    // jal (A3=31, Tnew 1) then jr $ra
    drive(0, 3, 0, 3, 31, 1);
    tick();
    drive(31, 0, 0, 0, 0, 0);
    chk("jr_stall", {7'd0, stall_D}, 0);
    chk("jr_fwd_rs_D", {6'd0, fwd_rs_D}, 3);
    tick();
    nops(3);

    // $0 producer/consumer
    drive(0, 1, 0, 1, 0, 3);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("r0_stall", {7'd0, stall_D}, 0);
    chk("r0_fwd", {4'd0, fwd_rs_D, fwd_rt_D}, 0);
    tick();
    nops(3);

    // div enters E, mflo held in D
    drive(4, 3, 5, 3, 0, 0, 1);
    chk("div_in_D_nostall", {7'd0, stall_D}, 0);
    tick();
    nst = 0;
    nb = 0;
    for (int i = 0; i < 20; i++) begin
      drive(0, 3, 0, 3, 12, 2, 1, (i == 0) ? 1 : 0, 1);
      if (stall_D) nst++;
      if (mdu_busy) nb++;
      tick();
    end
    chk("div_stall_cycles", 8'(nst), 11);
    chk("div_busy_cycles", 8'(nb), 10);
    nops(3);

    // flush while a lw-use stall is active
    drive(29, 1, 0, 3, 8, 3);
    tick();
    drive(8, 0, 0, 3, 10, 2, 0, 0, 0, 1);
    chk("flush_pre_stall", {7'd0, stall_D}, 1);
    tick();
    drive(8, 0, 8, 0, 0, 0);
    chk("flush_stall", {7'd0, stall_D}, 0);
    chk("flush_fwd", {fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E}, 0);
    tick();
    nops(3);

    // async reset mid-stall with the MDU counting
    drive(29, 1, 0, 3, 8, 3);
    tick();
    drive(8, 0, 0, 3, 10, 2, 0, 1, 1);
    chk("rst_pre_stall", {7'd0, stall_D}, 1);
    tick();
    drive(8, 0, 0, 3, 10, 2, 1);
    chk("rst_pre_busy", {7'd0, mdu_busy}, 1);
    #1 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    for (int k = 1; k <= 3; k++) pipe[k] = '{0, 0, 0, 0};
    busy_until = 0;
    @(negedge clk);
    reset_n = 1'b1;
    drive(8, 0, 0, 3, 10, 2, 1);
    chk("post_reset_stall", {7'd0, stall_D}, 0);
    tick();
    nops(3);

    // random traffic over a small register set to force collisions
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            ($urandom_range(0, 5) == 0) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
            $urandom_range(0, 1), ($urandom_range(0, 15) == 0) ? 1 : 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
